nibble_serial_addsub: RTL
=========================

NIBBLE_SERIAL_ADDSUB -- requirements
Module: nibble_serial_addsub

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request; accepted only when ready=1.
REQ-005 sub  input  1  operation select: 0 gives A+B, 1 gives A-B; sampled with start.
REQ-006 A  input  WIDTH  first operand; sampled on the accepting edge.
REQ-007 B  input  WIDTH  second operand; sampled on the accepting edge.
REQ-008 ready  output  1  high in IDLE and DONE, low in RUN.
REQ-009 done  output  1  one-cycle pulse when the result registers update.
REQ-010 S  output  WIDTH  registered result.
REQ-011 Co  output  1  registered final carry-out; for subtraction, 1 means no borrow.
REQ-012 V  output  1  registered two's-complement signed overflow.

Function
REQ-013 The block SHALL contain exactly one 4-bit ripple full-adder slice (sum = a^b^c; carry = c&(a^b) | a&b) and SHALL reuse it once per cycle across WIDTH/4 nibbles, LSB nibble first.
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 IDLE: if start=1, the block SHALL capture A, B and sub, clear the nibble index to 0, load the carry register with sub, and go to RUN; otherwise it SHALL stay in IDLE.
REQ-016 RUN: on each edge the slice SHALL add nibble k of A and nibble k of (sub ? ~B : B) with the carry register, store the 4-bit sum into nibble k of an internal result register, store the slice carry, and increment k.
REQ-017 RUN: after processing nibble WIDTH/4-1, the block SHALL load S, Co and V from the completed result and go to DONE.
REQ-018 V SHALL be the carry into the MSB XOR the carry out of the MSB, taken from the final nibble.
REQ-019 Latency: done SHALL be high exactly WIDTH/4 cycles after the accepting edge (4 cycles for WIDTH=16).
REQ-020 DONE: done=1 for this single cycle. If start=1 in DONE, it SHALL be accepted as in IDLE (back-to-back, next done exactly WIDTH/4 cycles later); otherwise the next state SHALL be IDLE.
REQ-021 start in RUN SHALL be ignored; the captured operands and sub SHALL NOT change mid-operation.
REQ-022 S, Co and V SHALL hold their value from the last completion until the next completion or reset; partial sums SHALL never appear on S.
REQ-023 Wrap-around: the result SHALL be modulo 2^WIDTH; the carry beyond the MSB appears only on Co.
REQ-024 A, B and sub changing while ready=0 SHALL have no effect.

Reset
REQ-025 With rst=1 on an edge: state SHALL become IDLE, ready=1, done=0, S=0, Co=0, V=0, and the internal nibble index, carry and operand registers SHALL clear to 0.
REQ-026 rst SHALL take priority over start and over any in-progress RUN; an aborted operation SHALL produce no done pulse, and S SHALL read 0.
REQ-027 On the first edge after rst deasserts, the block SHALL accept start as in IDLE.

Verification (WIDTH=16)
REQ-028 Add: A=0x1234, B=0x4321, sub=0 -> 4 cycles later done=1, S=0x5555, Co=0, V=0; ready=0 for the 3 intermediate cycles.
REQ-029 Carry and overflow: 0xFFFF+0x0001 -> S=0x0000, Co=1, V=0. Then 0x7FFF+0x0001 -> S=0x8000, Co=0, V=1.
REQ-030 Subtract: 0x0003-0x0005 -> S=0xFFFE, Co=0, V=0. Then 0x8000-0x0001 -> S=0x7FFF, Co=1, V=1.
REQ-031 Busy/back-to-back: pulse start with changed A/B two cycles after acceptance -> ignored, and the first result is unaffected. Assert start in the DONE cycle with 0x0001+0x0001 -> second done exactly 4 cycles later with S=0x0002.
REQ-032 Reset mid-operation: assert rst in the second RUN cycle of 0x1234+0x4321 -> next cycle ready=1, S=0x0000, and no done pulse follows. A new start then completes normally.
REQ-033 Random check: 1000 random A/B/sub values -> S, Co and V SHALL match a reference model of A±B, and every done SHALL arrive exactly 4 cycles after its accepting edge.

Source files
------------

// File: rtl/nibble_serial_addsub_if.sv
// Request/response bundle for the nibble-serial adder/subtractor.
// The master issues operands; the slave (datapath) returns the registered result.
interface nibble_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Co;
    logic             V;

    modport master (
        output start, sub, A, B,
        input  ready, done, S, Co, V
    );

    modport slave (
        input  start, sub, A, B,
        output ready, done, S, Co, V
    );
endinterface

// File: rtl/nibble_serial_addsub.sv
// Add/subtract of two WIDTH-bit operands using one 4-bit ripple slice,
// one nibble per clock, LSB nibble first; results held until the next completion.
module nibble_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    nibble_serial_addsub_if.slave   bus
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {carry out of bit 3, carry into bit 3, 4-bit sum}.
    function automatic logic [5:0] slice4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [4:0] c;
        logic [3:0] s;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (c[i] & (a[i] ^ b[i])) | (a[i] & b[i]);
        end
        return {c[4], c[3], s};
    endfunction

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             v_q, v_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic [IW+1:0]    base_s;
    logic [3:0]       a_nib_s;
    logic [3:0]       b_nib_s;
    logic [5:0]       slice_s;

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        res_d   = res_q;
        s_d     = s_q;
        co_d    = co_q;
        v_d     = v_q;
        done_d  = 1'b0;

        base_s  = {idx_q, 2'b00};
        a_nib_s = a_q[base_s +: 4];
        b_nib_s = sub_q ? ~b_q[base_s +: 4] : b_q[base_s +: 4];
        slice_s = slice4(a_nib_s, b_nib_s, carry_q);

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    sub_d   = bus.sub;
                    idx_d   = {IW{1'b0}};
                    carry_d = bus.sub;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d[base_s +: 4] = slice_s[3:0];
                carry_d            = slice_s[5];
                idx_d              = idx_q + {{(IW-1){1'b0}}, 1'b1};
                if (idx_q == IW'(NIB - 1)) begin
                    // Publish the whole word at once so S never shows a partial sum.
                    s_d     = res_d;
                    co_d    = slice_s[5];
                    v_d     = slice_s[5] ^ slice_s[4];
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d != RUN);
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= {IW{1'b0}};
            carry_q <= 1'b0;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sub_q   <= 1'b0;
            res_q   <= {WIDTH{1'b0}};
            s_q     <= {WIDTH{1'b0}};
            co_q    <= 1'b0;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            res_q   <= res_d;
            s_q     <= s_d;
            co_q    <= co_d;
            v_q     <= v_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.S     = s_q;
    assign bus.Co    = co_q;
    assign bus.V     = v_q;
endmodule
